// File: rtl/detection_feature_pingpong.sv
// -----------------------------------------------------------------------------
// detection_feature_pingpong
//
// Double-buffered (ping-pong) feature store. It sits between the Haar feature
// generator (producer) and the ANN classifier (consumer). The producer fills
// one bank with window n+1 while the consumer reads window n from the other.
// Each bank also holds its window's feature count and output-memory tag.
//
// Ports
//   iClk       : clock, all logic on the rising edge
//   iReset     : asynchronous, active-high reset
//   iWrreq     : producer writes iFeature this cycle
//   iFeature   : feature word from the generator
//   iLast      : qualifies iWrreq, this word closes the window
//   iTag       : window tag, captured on an accepted iLast write
//   oFull      : write bank is occupied, producer must hold iWrreq low
//   iRdaddr    : classifier read address within the ready bank
//   oFeature   : registered read data (one-cycle latency)
//   oValid     : read bank holds a complete window
//   oTag       : tag of the read bank
//   oCount     : number of features in the read bank
//   iDone      : classifier releases the read bank
//   oOverflow  : sticky protocol-error flag, cleared only by reset
// -----------------------------------------------------------------------------
module detection_feature_pingpong #(
   parameter int FEAT_W = 32,
   parameter int N_FEAT = 100,
   parameter int ADDR_W = 7,
   parameter int TAG_W  = 13
) (
   input  logic              iClk,
   input  logic              iReset,
   input  logic              iWrreq,
   input  logic [FEAT_W-1:0] iFeature,
   input  logic              iLast,
   input  logic [TAG_W-1:0]  iTag,
   output logic              oFull,
   input  logic [ADDR_W-1:0] iRdaddr,
   output logic [FEAT_W-1:0] oFeature,
   output logic              oValid,
   output logic [TAG_W-1:0]  oTag,
   output logic [ADDR_W:0]   oCount,
   input  logic              iDone,
   output logic              oOverflow
);

   localparam int MEM_DEPTH = 2 * N_FEAT;
   localparam int IDX_W     = $clog2(MEM_DEPTH);

   // The write address needs one extra bit so it can sit at N_FEAT after a
   // full-length window without an iLast; that value marks "window too long".
   localparam logic [ADDR_W:0]  N_FEAT_C   = (ADDR_W+1)'(N_FEAT);
   localparam logic [ADDR_W:0]  ADDR_ONE   = (ADDR_W+1)'(1);
   localparam logic [IDX_W-1:0] BANK1_BASE = IDX_W'(N_FEAT);

   typedef enum logic {
      EMPTY = 1'b0,
      READY = 1'b1
   } bank_state_e;

   bank_state_e       state_q [0:1];
   bank_state_e       state_d [0:1];
   logic [ADDR_W:0]   count_q [0:1];
   logic [ADDR_W:0]   count_d [0:1];
   logic [TAG_W-1:0]  tag_q   [0:1];
   logic [TAG_W-1:0]  tag_d   [0:1];
   logic              wbank_q, wbank_d;
   logic              rbank_q, rbank_d;
   logic [ADDR_W:0]   waddr_q, waddr_d;
   logic              overflow_q, overflow_d;
   logic [FEAT_W-1:0] feature_q, feature_d;

   logic [FEAT_W-1:0] mem [0:MEM_DEPTH-1];

   logic              full;
   logic              valid;
   logic              wr_accept;
   logic              wr_error;
   logic              rd_release;
   logic              rd_in_range;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;

   // Status is derived purely from registered state.
   assign full       = (state_q[wbank_q] == READY);
   assign valid      = (state_q[rbank_q] == READY);
   assign wr_accept  = iWrreq && !full && (waddr_q < N_FEAT_C);
   assign wr_error   = iWrreq && !wr_accept;
   assign rd_release = iDone && valid;

   // Bank 0 occupies words [0, N_FEAT), bank 1 occupies [N_FEAT, 2*N_FEAT).
   assign wr_idx = IDX_W'(waddr_q) + (wbank_q ? BANK1_BASE : '0);
   assign rd_idx = IDX_W'(iRdaddr) + (rbank_q ? BANK1_BASE : '0);
   assign rd_in_range = ({1'b0, iRdaddr} < N_FEAT_C);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d    = state_q;
      count_d    = count_q;
      tag_d      = tag_q;
      wbank_d    = wbank_q;
      rbank_d    = rbank_q;
      waddr_d    = waddr_q;
      overflow_d = overflow_q;

      if (wr_error) begin
         overflow_d = 1'b1;
      end

      if (wr_accept) begin
         waddr_d = waddr_q + ADDR_ONE;
         if (iLast) begin
            count_d[wbank_q] = waddr_q + ADDR_ONE;
            tag_d[wbank_q]   = iTag;
            state_d[wbank_q] = READY;
            wbank_d          = ~wbank_q;
            waddr_d          = '0;
         end
      end

      // A release and a closing write always target different banks: when the
      // pointers coincide, a READY read bank means the write is blocked.
      if (rd_release) begin
         state_d[rbank_q] = EMPTY;
         rbank_d          = ~rbank_q;
      end

      // Out-of-range read addresses keep the previous word rather than index
      // past the array; such reads are beyond oCount and carry no meaning.
      feature_d = rd_in_range ? mem[rd_idx] : feature_q;
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         for (int b = 0; b < 2; b++) begin
            state_q[b] <= EMPTY;
            count_q[b] <= '0;
            tag_q[b]   <= '0;
         end
         wbank_q    <= 1'b0;
         rbank_q    <= 1'b0;
         waddr_q    <= '0;
         overflow_q <= 1'b0;
         feature_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed above.
         state_q    <= state_d;
         count_q    <= count_d;
         tag_q      <= tag_d;
         wbank_q    <= wbank_d;
         rbank_q    <= rbank_d;
         waddr_q    <= waddr_d;
         overflow_q <= overflow_d;
         feature_q  <= feature_d;
      end
   end

   // NOTE: the feature array has no reset; its contents are only meaningful
   // behind a READY bank, so clearing it would buy nothing and block RAM
   // inference.
   always_ff @(posedge iClk) begin
      if (wr_accept) begin
         mem[wr_idx] <= iFeature;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign oFull     = full;
   assign oValid    = valid;
   assign oTag      = tag_q[rbank_q];
   assign oCount    = count_q[rbank_q];
   assign oFeature  = feature_q;
   assign oOverflow = overflow_q;

endmodule

// File: tb/tb_detection_feature_pingpong.sv
// -----------------------------------------------------------------------------
// tb_detection_feature_pingpong
//
// Self-checking bench for detection_feature_pingpong. The reference model sees
// the store as a FIFO of at most two completed windows plus one window under
// construction; full means two windows are waiting, valid means at least one.
// -----------------------------------------------------------------------------
module tb_detection_feature_pingpong;

   localparam int FEAT_W = 32;
   localparam int N_FEAT = 100;
   localparam int ADDR_W = 7;
   localparam int TAG_W  = 13;

   logic              iClk;
   logic              iReset;
   logic              iWrreq;
   logic [FEAT_W-1:0] iFeature;
   logic              iLast;
   logic [TAG_W-1:0]  iTag;
   logic              oFull;
   logic [ADDR_W-1:0] iRdaddr;
   logic [FEAT_W-1:0] oFeature;
   logic              oValid;
   logic [TAG_W-1:0]  oTag;
   logic [ADDR_W:0]   oCount;
   logic              iDone;
   logic              oOverflow;

   detection_feature_pingpong #(
      .FEAT_W (FEAT_W),
      .N_FEAT (N_FEAT),
      .ADDR_W (ADDR_W),
      .TAG_W  (TAG_W)
   ) dut (
      .iClk      (iClk),
      .iReset    (iReset),
      .iWrreq    (iWrreq),
      .iFeature  (iFeature),
      .iLast     (iLast),
      .iTag      (iTag),
      .oFull     (oFull),
      .iRdaddr   (iRdaddr),
      .oFeature  (oFeature),
      .oValid    (oValid),
      .oTag      (oTag),
      .oCount    (oCount),
      .iDone     (iDone),
      .oOverflow (oOverflow)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [TAG_W-1:0]               tag;
      int                             cnt;
      logic [N_FEAT-1:0][FEAT_W-1:0]  data;
   } win_t;

   win_t ready_q[$];   // completed windows, oldest first
   win_t cur;          // window under construction
   int   cur_len;
   bit   ovf;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      ready_q.delete();
      cur_len = 0;
      ovf     = 1'b0;
   endtask

   function automatic logic [ADDR_W-1:0] rnd_rd();
      if (ready_q.size() > 0)
         return ADDR_W'($urandom_range(ready_q[0].cnt - 1, 0));
      return ADDR_W'($urandom_range((1 << ADDR_W) - 1, 0));
   endfunction

   // One clock cycle: drive at the falling edge, update the model at the
   // rising edge, check every visible output at the next falling edge.
   task automatic cycle(input logic wr, input logic [FEAT_W-1:0] f, input logic last,
                        input logic [TAG_W-1:0] tag, input logic done,
                        input logic [ADDR_W-1:0] rd);
      bit               pre_valid, pre_full, chk_rd;
      logic [FEAT_W-1:0] exp_rd;
      win_t             dropped;
      iWrreq   = wr;
      iFeature = f;
      iLast    = last;
      iTag     = tag;
      iDone    = done;
      iRdaddr  = rd;
      pre_valid = (ready_q.size() > 0);
      pre_full  = (ready_q.size() == 2);
      chk_rd    = pre_valid && (int'(rd) < ready_q[0].cnt);
      exp_rd    = chk_rd ? ready_q[0].data[rd] : '0;
      @(posedge iClk);
      if (wr) begin
         if (pre_full || cur_len == N_FEAT) begin
            ovf = 1'b1;
         end else begin
            cur.data[cur_len] = f;
            cur_len++;
            if (last) begin
               cur.tag = tag;
               cur.cnt = cur_len;
               ready_q.push_back(cur);
               cur_len = 0;
            end
         end
      end
      if (done && pre_valid) dropped = ready_q.pop_front();
      @(negedge iClk);
      iWrreq = 1'b0;
      iLast  = 1'b0;
      iDone  = 1'b0;
      chk("valid",    oValid,    ready_q.size() > 0);
      chk("full",     oFull,     ready_q.size() == 2);
      chk("overflow", oOverflow, ovf);
      if (ready_q.size() > 0) begin
         chk("tag",   oTag,   ready_q[0].tag);
         chk("count", oCount, ready_q[0].cnt);
      end
      if (chk_rd) chk("rdata", oFeature, exp_rd);
   endtask

   task automatic write_window(input logic [TAG_W-1:0] tag, input int len,
                               input bit done_on_last, input bit index_data);
      for (int i = 0; i < len; i++) begin
         cycle(1'b1, index_data ? FEAT_W'(i) : FEAT_W'($urandom), i == len - 1, tag,
               done_on_last && (i == len - 1), rnd_rd());
      end
   endtask

   task automatic read_all();
      int n;
      n = (ready_q.size() > 0) ? ready_q[0].cnt : 0;
      for (int a = 0; a < n; a++) begin
         cycle(1'b0, '0, 1'b0, '0, 1'b0, ADDR_W'(a));
      end
   endtask

   task automatic release_rd();
      cycle(1'b0, '0, 1'b0, '0, 1'b1, rnd_rd());
   endtask

   // Reset is raised between clock edges and the outputs are checked before
   // any rising edge occurs, which exercises the asynchronous path.
   task automatic do_reset();
      iReset = 1'b1;
      #1;
      model_reset();
      chk("rst_valid",    oValid,    1'b0);
      chk("rst_full",     oFull,     1'b0);
      chk("rst_overflow", oOverflow, 1'b0);
      chk("rst_tag",      oTag,      '0);
      chk("rst_count",    oCount,    '0);
      chk("rst_feature",  oFeature,  '0);
      @(negedge iClk);
      iReset = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence with randomized data, tags and window lengths
   // ---------------------------------------------------------------------------
   initial begin
      iReset   = 1'b0;
      iWrreq   = 1'b0;
      iFeature = '0;
      iLast    = 1'b0;
      iTag     = '0;
      iDone    = 1'b0;
      iRdaddr  = '0;
      cur_len  = 0;
      ovf      = 1'b0;
      #2;
      do_reset();

      // Single full-length window, value = index, tag 0x0A5.
      write_window(13'h0A5, N_FEAT, 1'b0, 1'b1);
      chk("single_valid", oValid, 1'b1);
      chk("single_count", oCount, 100);
      chk("single_tag",   oTag,   13'h0A5);
      chk("single_full",  oFull,  1'b0);
      read_all();

      // Ping-pong overlap: window tag 1, then tag 2 written while reading.
      release_rd();
      write_window(13'd1, int'($urandom_range(20, 5)), 1'b0, 1'b0);
      write_window(13'd2, int'($urandom_range(30, 8)), 1'b0, 1'b0);
      chk("pp_full_after_second", oFull, 1'b1);
      read_all();
      release_rd();
      chk("pp_tag_switch",   oTag,   13'd2);
      chk("pp_valid_kept",   oValid, 1'b1);
      chk("pp_full_dropped", oFull,  1'b0);

      // Write while full: both windows READY, then writes are refused.
      write_window(13'($urandom), int'($urandom_range(N_FEAT, 1)), 1'b0, 1'b0);
      chk("wf_full", oFull, 1'b1);
      cycle(1'b1, FEAT_W'($urandom), 1'b0, '0, 1'b0, rnd_rd());
      cycle(1'b1, FEAT_W'($urandom), 1'b1, 13'h1FFF, 1'b0, rnd_rd());
      chk("wf_overflow", oOverflow, 1'b1);
      read_all();
      release_rd();
      read_all();

      // Closing write and release in the same cycle.
      write_window(13'($urandom), int'($urandom_range(40, 2)), 1'b1, 1'b0);
      chk("sim_valid", oValid, 1'b1);
      chk("sim_full",  oFull,  1'b0);
      read_all();

      // Over-length window: N_FEAT+1 words without iLast, then a closing word.
      do_reset();
      for (int i = 0; i <= N_FEAT; i++) begin
         cycle(1'b1, FEAT_W'($urandom), 1'b0, '0, 1'b0, rnd_rd());
      end
      chk("ol_overflow", oOverflow, 1'b1);
      cycle(1'b1, FEAT_W'($urandom), 1'b1, 13'h0042, 1'b0, rnd_rd());
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, '0, 1'b0, '0, 1'b0, rnd_rd());
      end
      chk("ol_valid_low", oValid, 1'b0);

      // Async reset in the middle of a window with one bank READY.
      do_reset();
      write_window(13'($urandom), int'($urandom_range(12, 3)), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, FEAT_W'($urandom), 1'b0, '0, 1'b0, rnd_rd());
      end
      do_reset();
      write_window(13'h0ABC, 3, 1'b0, 1'b0);
      chk("post_rst_count", oCount, 3);
      chk("post_rst_tag",   oTag,   13'h0ABC);
      read_all();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
